modexp_ctrl_unit: RTL



---
 rtl/rsa_ctrl_pkg.sv | 41 ++++
 rtl/modexp_ctrl_unit_if.sv | 18 +
 rtl/modexp_step_timer.sv | 52 +++++
 rtl/modexp_ctrl_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rsa_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsa_ctrl_pkg
// Description : Shared state encoding, operand-mux encodings and state-class
//               helpers for the modular-exponentiation control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package rsa_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_PRE_MAP    = 4'd1,
        ST_MAP        = 4'd2,
        ST_POST_MAP   = 4'd3,
        ST_PRE_MMM    = 4'd4,
        ST_MMM        = 4'd5,
        ST_POST_MMM   = 4'd6,
        ST_PRE_REMAP  = 4'd7,
        ST_REMAP      = 4'd8,
        ST_POST_REMAP = 4'd9,
        ST_DONE       = 4'd10
    } state_e;

    localparam logic [1:0] SEL1_MAP   = 2'b00;
    localparam logic [1:0] SEL1_MMM   = 2'b01;
    localparam logic [1:0] SEL1_REMAP = 2'b10;

    function automatic logic is_pre(input state_e s);
        return (s == ST_PRE_MAP) || (s == ST_PRE_MMM) || (s == ST_PRE_REMAP);
    endfunction

    function automatic logic is_core(input state_e s);
        return (s == ST_MAP) || (s == ST_MMM) || (s == ST_REMAP);
    endfunction

    function automatic logic is_post(input state_e s);
        return (s == ST_POST_MAP) || (s == ST_POST_MMM) || (s == ST_POST_REMAP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/modexp_ctrl_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : modexp_ctrl_unit_if
// Description : Host-side start/busy/done handshake and exponent bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface modexp_ctrl_unit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] expE;
    logic             busy;
    logic             done;

    modport master (output start, output expE, input busy, input done);
    modport slave  (input start, input expE, output busy, output done);
endinterface
`default_nettype wire

// File: rtl/modexp_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : modexp_step_timer
// Description : Core-phase step counter with a registered terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module modexp_step_timer #(
    parameter int MMM_CYCLES = 10
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_ena,
    input  wire logic i_abort,
    input  wire logic i_clr,
    input  wire logic i_inc,
    output logic      o_tc
);
    localparam int             SW     = $clog2(MMM_CYCLES + 1);
    localparam logic [SW-1:0]  C_LAST = SW'(MMM_CYCLES - 1);

    logic [SW-1:0] count_q, count_d;
    logic          tc_q, tc_d;

    always_comb begin
        count_d = count_q;
        if (i_abort) begin
            count_d = '0;
        end else if (i_ena) begin
            if (i_clr) begin
                count_d = '0;
            end else if (i_inc) begin
                count_d = count_q + SW'(1);
            end
        end
        // Flag is computed one cycle ahead so it lines up with the last core step.
        tc_d = (i_abort || i_ena) ? (count_d == C_LAST) : tc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign o_tc = tc_q;

endmodule
`default_nettype wire

// File: rtl/modexp_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : modexp_ctrl_unit
// Description : Square-and-multiply sequencer driving the Montgomery multiplier
//               through map-in, WIDTH exponent rounds and remap-out.
//               Optional MODEXP_EARLY_EXIT_EN stops rounds once the exponent
//               has no set bits left.
// Revision    : 1.0 - initial release
// ============================================================================
module modexp_ctrl_unit
    import rsa_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MMM_CYCLES = 10
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      ena,
    input  wire logic                      clear,
    modexp_ctrl_unit_if.slave              host,
    output logic                           rst_mmm,
    output logic                           ld_a,
    output logic                           ld_r,
    output logic                           lock1,
    output logic                           lock2,
    output logic [1:0]                     sel1,
    output logic                           sel2,
    output logic [$clog2(WIDTH+1)-1:0]     round_idx
);
    localparam int            RW           = $clog2(WIDTH + 1);
    localparam logic [RW-1:0] C_LAST_ROUND = RW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [RW-1:0]    round_q, round_d;
    logic             busy_q, busy_d, done_q, done_d, rst_mmm_q, rst_mmm_d;
    logic             ld_a_q, ld_a_d, ld_r_q, ld_r_d;
    logic             lock1_q, lock1_d, lock2_q, lock2_d, sel2_q, sel2_d;
    logic [1:0]       sel1_q, sel1_d;
    logic [WIDTH-1:0] w_exp_shift;
    logic             w_tc;

    assign w_exp_shift = exp_q >> 1;

    modexp_step_timer #(
        .MMM_CYCLES (MMM_CYCLES)
    ) u_step_timer (
        .clk     (clk),
        .rst     (rst),
        .i_ena   (ena),
        .i_abort (clear),
        .i_clr   (is_post(state_q)),
        .i_inc   (is_core(state_q)),
        .o_tc    (w_tc)
    );

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        round_d = round_q;
        if (clear) begin
            state_d = ST_IDLE;
            round_d = '0;
        end else if (ena) begin
            unique case (state_q)
                ST_IDLE:       if (host.start) state_d = ST_PRE_MAP;
                ST_PRE_MAP:    state_d = ST_MAP;
                ST_MAP:        if (w_tc) state_d = ST_POST_MAP;
                ST_POST_MAP: begin
                    exp_d   = host.expE;
                    round_d = '0;
`ifdef MODEXP_EARLY_EXIT_EN
                    state_d = (host.expE == '0) ? ST_PRE_REMAP : ST_PRE_MMM;
`else
                    state_d = ST_PRE_MMM;
`endif
                end
                ST_PRE_MMM:    state_d = ST_MMM;
                ST_MMM:        if (w_tc) state_d = ST_POST_MMM;
                ST_POST_MMM: begin
                    exp_d   = w_exp_shift;
                    round_d = round_q + RW'(1);
                    if (round_q == C_LAST_ROUND) begin
                        state_d = ST_PRE_REMAP;
`ifdef MODEXP_EARLY_EXIT_EN
                    end else if (w_exp_shift == '0) begin
                        state_d = ST_PRE_REMAP;
`endif
                    end else begin
                        state_d = ST_PRE_MMM;
                    end
                end
                ST_PRE_REMAP:  state_d = ST_REMAP;
                ST_REMAP:      if (w_tc) state_d = ST_POST_REMAP;
                ST_POST_REMAP: state_d = ST_DONE;
                ST_DONE:       state_d = ST_IDLE;
                default:       state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs decode the next state so the registered copies align with state_q.
    always_comb begin
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        rst_mmm_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        ld_a_d    = is_pre(state_d);
        ld_r_d    = is_post(state_d);
        lock1_d   = 1'b0;
        lock2_d   = 1'b0;
        sel1_d    = SEL1_MAP;
        sel2_d    = 1'b0;
        unique case (state_d)
            ST_PRE_MAP, ST_MAP, ST_POST_MAP: begin
                lock1_d = 1'b1;
                lock2_d = 1'b1;
            end
            ST_PRE_MMM, ST_MMM, ST_POST_MMM: begin
                lock1_d = exp_d[0];
                lock2_d = 1'b1;
                sel1_d  = SEL1_MMM;
                sel2_d  = 1'b1;
            end
            ST_PRE_REMAP, ST_REMAP, ST_POST_REMAP: begin
                lock1_d = 1'b1;
                sel1_d  = SEL1_REMAP;
                sel2_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            exp_q     <= '0;
            round_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rst_mmm_q <= 1'b0;
            ld_a_q    <= 1'b0;
            ld_r_q    <= 1'b0;
            lock1_q   <= 1'b0;
            lock2_q   <= 1'b0;
            sel1_q    <= SEL1_MAP;
            sel2_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            round_q   <= round_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rst_mmm_q <= rst_mmm_d;
            ld_a_q    <= ld_a_d;
            ld_r_q    <= ld_r_d;
            lock1_q   <= lock1_d;
            lock2_q   <= lock2_d;
            sel1_q    <= sel1_d;
            sel2_q    <= sel2_d;
        end
    end

    assign host.busy = busy_q;
    assign host.done = done_q;
    assign rst_mmm   = rst_mmm_q;
    assign ld_a      = ld_a_q;
    assign ld_r      = ld_r_q;
    assign lock1     = lock1_q;
    assign lock2     = lock2_q;
    assign sel1      = sel1_q;
    assign sel2      = sel2_q;
    assign round_idx = round_q;

endmodule
`default_nettype wire
